lfsr_stream_decoder: RTL
========================

Name: lfsr_stream_decoder

Overview:
- Receive-side counterpart of the 6-bit LFSR encryptor. Consumes a ciphertext byte stream.
- Recovers the unknown tap pattern and seed from a known preamble, then decrypts the payload.
- Emits plaintext on a valid/ready stream with the preamble stripped.
- Sits between the ciphertext memory reader and the plaintext writer.

Parameters:
- PRE_LEN, 7, number of preamble bytes at message start (range 2..15).
- PRE_CHAR, 8'h5F, plaintext value of every preamble byte.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a new message
- in_valid  in  1  ciphertext byte present
- in_ready  out  1  decoder accepts in_data this cycle
- in_data  in  8  ciphertext byte
- in_last  in  1  marks final ciphertext byte
- out_valid  out  1  plaintext byte present
- out_ready  in  1  downstream accepts out_data
- out_data  out  8  plaintext byte
- out_last  out  1  final plaintext byte
- locked  out  1  tap/seed recovered; payload decoding active
- tap_sel  out  3  index of recovered tap pattern (0..5)
- seed  out  6  recovered LFSR start state
- done  out  1  message fully delivered (level)
- err  out  1  no candidate matched, or in_last arrived inside the preamble (level)

Behaviour:
- Encryption model (fixed):
  - cipher[i] = plain[i] ^ {2'b00, s_i}
  - s_0 = seed
  - s_{i+1} = {s_i[4:0], ^(s_i & taps)}
- Candidate taps by index 0..5: 6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39.
- Reset (async, rst_n=0): state IDLE; in_ready, out_valid, out_last, locked, done, err = 0; tap_sel, seed, out_data = 0; alive mask = 0.
- FSM states: IDLE, SEARCH, DECODE, DONE, FAIL.
- start in any state: clears locked/done/err/out_valid and the preamble counter, sets the alive mask to 6'b111111, enters SEARCH. start wins over any transfer in the same cycle; that byte is not consumed (in_ready=0 while start=1).
- IDLE / DONE / FAIL: in_ready=0. DONE asserts done; FAIL asserts err. Both hold until start.
- SEARCH: in_ready=1; one byte per accepted handshake; counter k runs 0..PRE_LEN-1; no output.
  - k=0: every candidate state := in_data[5:0] ^ PRE_CHAR[5:0]; seed register latches the same value. If in_data[7:6] != PRE_CHAR[7:6], alive := 0. Then each candidate advances once.
  - k>0: alive[c] &= (in_data == PRE_CHAR ^ {2'b00, st[c]}). Then every candidate advances with its own taps.
  - After the byte with k=PRE_LEN-1: if alive != 0, tap_sel = lowest set index, locked=1, go DECODE. Otherwise go FAIL.
  - in_last=1 on any accepted preamble byte: go FAIL immediately.
- DECODE: single-register output stage.
  - in_ready = !out_valid || out_ready.
  - On an accepted byte: out_data <= in_data ^ {2'b00, st[tap_sel]}, out_last <= in_last, out_valid <= 1, selected state advances.
  - Latency: 1 cycle input→output; full throughput of 1 byte/cycle when out_ready=1.
  - out_valid/out_data/out_last hold stable while out_valid && !out_ready.
  - Accepted out_last transfer: out_valid drops, locked stays, go DONE.
- Unselected candidate states are don't-care after lock.
- in_valid while in_ready=0 is ignored; upstream holds the data.
- Reset mid-message: everything returns to reset values immediately. A partially delivered message is lost.

Test Plan:
- Taps 6'h21, seed 6'h01, PRE_LEN=7, then 'H'.
  - Stimulus: start, then 5E,5C,58,50,40,60,61,75(last), out_ready=1.
  - Required: locked=1 with tap_sel=0 and seed=01 after the 7th byte; one output 8'h48 with out_last; done=1; no other outputs.
- Backpressure: same stream plus extra payload, out_ready toggling 1/0 every cycle.
  - Required: plaintext order and values unchanged; out_data stable while stalled; no byte dropped or duplicated.
- Corrupt preamble byte 3 (50→51).
  - Required: err=1 after the 7th byte; in_ready=0; no out_valid.
- in_last asserted on preamble byte 2.
  - Required: FAIL immediately, err=1, locked=0.
- start pulse mid-DECODE, then the correct stream again.
  - Required: pending output discarded; clean relock; correct plaintext delivered.
- rst_n low for 1 cycle mid-SEARCH.
  - Required: all outputs 0 asynchronously; in_ready=0 until the next start.

Source files
------------

// File: rtl/lfsr_stream_decoder.sv
// Receive-side decoder for the 6-bit LFSR stream cipher: recovers tap pattern and
// seed from a known preamble, then emits decrypted payload on a valid/ready stream.
module lfsr_stream_decoder #(
  parameter int          PRE_LEN  = 7,
  parameter logic [7:0]  PRE_CHAR = 8'h5F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       locked,
  output logic [2:0] tap_sel,
  output logic [5:0] seed,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, SEARCH, DECODE, DONE, FAIL} state_t;

  state_t     state;
  logic [3:0] k;
  logic [5:0] alive;
  logic [5:0] alive_nxt;
  logic [5:0] match;
  logic [5:0] st [6];
  logic [5:0] init_st;
  logic [5:0] key;
  logic [2:0] first_alive;
  logic       in_fire;
  logic       out_fire;

  function automatic logic [5:0] tap_of(input logic [2:0] idx);
    case (idx)
      3'd0:    tap_of = 6'h21;
      3'd1:    tap_of = 6'h2D;
      3'd2:    tap_of = 6'h30;
      3'd3:    tap_of = 6'h33;
      3'd4:    tap_of = 6'h36;
      default: tap_of = 6'h39;
    endcase
  endfunction

  function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] t);
    step = {s[4:0], ^(s & t)};
  endfunction

  assign key     = st[tap_sel];
  assign init_st = in_data[5:0] ^ PRE_CHAR[5:0];

  // Once the final byte sits in the output register no further input is taken.
  assign in_ready = !start &&
                    ((state == SEARCH) ||
                     ((state == DECODE) && !(out_valid && out_last) && (!out_valid || out_ready)));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    match       = '0;
    alive_nxt   = '0;
    first_alive = '0;
    for (int c = 0; c < 6; c++) begin
      match[c] = (in_data == (PRE_CHAR ^ {2'b00, st[c]}));
    end
    if (k == 4'd0) begin
      alive_nxt = (in_data[7:6] == PRE_CHAR[7:6]) ? alive : 6'b000000;
    end else begin
      alive_nxt = alive & match;
    end
    for (int c = 5; c >= 0; c--) begin
      if (alive_nxt[c]) first_alive = 3'(c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      alive     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      locked    <= 1'b0;
      tap_sel   <= '0;
      seed      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int c = 0; c < 6; c++) st[c] <= '0;
    end else if (start) begin
      state     <= SEARCH;
      k         <= '0;
      alive     <= 6'b111111;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      locked    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (in_fire) begin
            alive <= alive_nxt;
            k     <= k + 4'd1;
            // The first byte seeds every candidate; later bytes test and advance them.
            if (k == 4'd0) begin
              seed <= init_st;
              for (int c = 0; c < 6; c++) st[c] <= step(init_st, tap_of(3'(c)));
            end else begin
              for (int c = 0; c < 6; c++) st[c] <= step(st[c], tap_of(3'(c)));
            end
            if (in_last) begin
              err   <= 1'b1;
              state <= FAIL;
            end else if (k == 4'(PRE_LEN - 1)) begin
              if (alive_nxt != 6'b000000) begin
                tap_sel <= first_alive;
                locked  <= 1'b1;
                state   <= DECODE;
              end else begin
                err   <= 1'b1;
                state <= FAIL;
              end
            end
          end
        end
        DECODE: begin
          if (in_fire) begin
            out_data     <= in_data ^ {2'b00, key};
            out_last     <= in_last;
            out_valid    <= 1'b1;
            st[tap_sel]  <= step(key, tap_of(tap_sel));
          end else if (out_fire) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
